// File: rtl/uart_pkg.sv
// Shared types and width helpers for the framed UART transmitter.
package uart_pkg;

    // Per-frame parity selection; the unused code 2'b11 behaves like PAR_NONE.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    // Framing FSM states, in the order they appear on the line.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Bits needed to index n distinct values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with power-of-2 depth. Pointers wrap naturally; the
// level counter carries one extra bit so full and empty are distinct.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    // A push into a full FIFO is dropped even when a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end

    // Storage array write port.
    // NOTE: the array is deliberately not reset; pointers and level define validity, and a reset would block RAM inference.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // Pointer and level registers.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: FIFO-buffered words serialised LSB-first with
// per-frame parity and stop-bit count latched when the word is popped.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 139,
    parameter int WORDBITS     = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [WORDBITS-1:0]           tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = clog2_min1(CLKS_PER_BIT);
    localparam int BW = clog2_min1(WORDBITS + 1);

    tx_state_e           state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORDBITS-1:0] shift_q, shift_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                tx_out_q, tx_out_d;
    logic                rdy_en_q;

    logic                fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [WORDBITS-1:0] fifo_dout;
    logic                bit_end;

    uart_sync_fifo #(
        .WIDTH (WORDBITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (tx_valid && tx_ready),
        .pop     (fifo_pop),
        .din     (tx_data),
        .dout    (fifo_dout),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Ready depends only on registered state: held low until the first edge after reset.
    assign tx_ready = rdy_en_q && !fifo_full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign tx_out   = tx_out_q;
    assign bit_end  = (timer_q == TW'(CLKS_PER_BIT - 1));

    // Framing FSM next state; tx_out_d is the line level for the current state.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_out_d  = 1'b1;
        fifo_pop  = 1'b0;

        if (state_q != ST_IDLE) timer_d = bit_end ? '0 : timer_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    // Frame configuration is captured here and frozen for the whole frame.
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    par_en_d  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                    par_bit_d = (^fifo_dout) ^ (parity_mode == PAR_ODD);
                    stop2_d   = two_stop;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                tx_out_d = 1'b0;
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_out_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BW'(WORDBITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_out_d = par_bit_q;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                tx_out_d = 1'b1;
                if (bit_end) begin
                    // bit_cnt_q counts the stop bits already sent.
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BW'(1);
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, datapath and registered line output; reset forces the line idle at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_out_q  <= 1'b1;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_out_q  <= tx_out_d;
            rdy_en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: directed frame vectors, multi-cycle
// corner sequences, and random traffic against a frame-level reference model.
module tb_uart_tx_framed;

    localparam int CPB   = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int LVW   = $clog2(DEPTH) + 1;

    logic           clock    = 1'b0;
    logic           reset_n  = 1'b1;
    logic [W-1:0]   tx_data  = '0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [1:0]     parity_mode = 2'b00;
    logic           two_stop = 1'b0;
    logic           tx_out;
    logic           busy;
    logic [LVW-1:0] fifo_level;

    uart_tx_framed #(
        .CLKS_PER_BIT (CPB),
        .WORDBITS     (W),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx_out      (tx_out),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // ---------------- reference model: frames as bit lists ----------------
    logic [W-1:0] mq[$];
    int  t           = 0;
    int  next_pop_t  = 0;
    int  pop_t       = -1000;
    int  frame_start = -1000;
    int  flen        = 0;
    bit  fbits[16];
    bit  ready_en    = 1'b0;

    function automatic void model_reset();
        mq.delete();
        next_pop_t  = 0;
        pop_t       = -1000;
        frame_start = -1000;
        flen        = 0;
        ready_en    = 1'b0;
    endfunction

    // Build the line bit list for one word: start, data LSB first, parity, stops.
    function automatic void start_frame(input logic [W-1:0] w, input logic [1:0] pm, input logic ts);
        int n;
        n = 0;
        fbits[n] = 1'b0; n++;
        for (int i = 0; i < W; i++) begin
            fbits[n] = w[i]; n++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            fbits[n] = (^w) ^ (pm == 2'b10); n++;
        end
        fbits[n] = 1'b1; n++;
        if (ts) begin
            fbits[n] = 1'b1; n++;
        end
        pop_t       = t;
        frame_start = t + 1;
        flen        = n * CPB;
        next_pop_t  = t + flen + 1;
    endfunction

    always @(posedge clock) begin : monitor
        logic         v;
        logic [W-1:0] d;
        logic [1:0]   pm;
        logic         ts;
        int           cnt;
        bit           rdy;
        logic         exp_tx;
        t++;
        if (!reset_n) begin
            ready_en = 1'b0;
        end else begin
            v   = tx_valid;
            d   = tx_data;
            pm  = parity_mode;
            ts  = two_stop;
            cnt = mq.size();
            rdy = ready_en && (cnt != DEPTH);
            if (t >= next_pop_t && cnt > 0) start_frame(mq.pop_front(), pm, ts);
            if (v && rdy) mq.push_back(d);
            ready_en = 1'b1;
            #2;
            if (reset_n) begin
                exp_tx = (t >= frame_start && t < frame_start + flen) ? fbits[(t - frame_start) / CPB] : 1'b1;
                check("mon_tx_out", tx_out, exp_tx);
                check("mon_busy", busy, (mq.size() != 0) || (t >= pop_t && t < pop_t + flen));
                check("mon_level", fifo_level, mq.size());
                check("mon_ready", tx_ready, mq.size() != DEPTH);
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0]  data;
        logic [1:0]  pmode;
        logic        ts;
        int          nbits;
        logic [15:0] line;   // bit i = i-th bit on the line
    } vec_t;

    vec_t vecs[7];

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic send_check(input string tag, input vec_t v);
        int          e;
        int          len;
        logic [15:0] got;
        wait_idle(tag);
        parity_mode = v.pmode;
        two_stop    = v.ts;
        tx_data     = v.data;
        tx_valid    = 1'b1;
        check({tag, "_ready"}, tx_ready, 1'b1);
        tick();
        e = cyc;
        tx_valid = 1'b0;
        tick();
        check({tag, "_lat_high"}, tx_out, 1'b1);
        tick();
        check({tag, "_lat_low"}, tx_out, 1'b0);
        got = '0;
        tick();
        for (int b = 0; b < v.nbits; b++) begin
            got[b] = tx_out;
            if (b != v.nbits - 1) repeat (CPB) tick();
        end
        check({tag, "_line"}, got, v.line);
        len = v.nbits * CPB;
        while (cyc < e + len) tick();
        check({tag, "_busy_last"}, busy, 1'b1);
        tick();
        check({tag, "_busy_fall"}, busy, 1'b0);
        check({tag, "_last_stop"}, tx_out, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int e;
        int acc;
        int run;
        int n;
        bit rdy;

        vecs[0] = '{8'hA5, 2'b00, 1'b0, 10, 16'h034A};
        vecs[1] = '{8'h07, 2'b01, 1'b0, 11, 16'h060E};
        vecs[2] = '{8'h07, 2'b10, 1'b0, 11, 16'h040E};
        vecs[3] = '{8'h07, 2'b11, 1'b0, 10, 16'h020E};
        vecs[4] = '{8'h00, 2'b01, 1'b1, 12, 16'h0C00};
        vecs[5] = '{8'hFF, 2'b10, 1'b1, 12, 16'h0FFE};
        vecs[6] = '{8'h5A, 2'b00, 1'b1, 11, 16'h06B4};

        // Reset state
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", tx_ready, 1'b0);
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", tx_ready, 1'b1);

        // Table-driven frames
        for (int i = 0; i < 7; i++) send_check($sformatf("vec%0d", i), vecs[i]);

        // Two stop bits, back-to-back words, two_stop toggled mid-frame
        wait_idle("ts");
        parity_mode = 2'b00;
        two_stop    = 1'b1;
        tx_data     = 8'h3C;
        tx_valid    = 1'b1;
        tick();
        e = cyc;
        tx_data = 8'hC3;
        tick();
        tx_valid = 1'b0;
        while (cyc < e + 10) tick();
        two_stop = 1'b0;
        while (cyc < e + 30) tick();
        two_stop = 1'b1;
        while (cyc < e + 37) tick();
        check("ts_data_msb", tx_out, 1'b0);
        tick();
        run = 0;
        while (tx_out && run < 20) begin
            run++;
            tick();
        end
        check("ts_high_run", run, 9);
        check("ts_second_start", tx_out, 1'b0);

        // Fill the FIFO from idle with tx_valid held for 20 cycles
        wait_idle("full");
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        acc         = 0;
        tx_valid    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tx_data = W'($urandom);
            rdy = tx_ready;
            tick();
            if (i == 0) e = cyc;
            if (rdy) acc++;
        end
        tx_valid = 1'b0;
        check("full_accepted", acc, 17);
        check("full_level", fifo_level, 16);
        check("full_ready_low", tx_ready, 1'b0);
        n = 0;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        check("full_ready_rise_cycle", cyc - e, 42);
        check("full_level_after_pop", fifo_level, 15);

        // Reset during the third data bit, with a second word queued
        wait_idle("rst");
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        tx_data     = 8'h9A;
        tx_valid    = 1'b1;
        tick();
        e = cyc;
        tx_data = 8'h3D;
        tick();
        tx_valid = 1'b0;
        while (cyc < e + 15) tick();
        check("mid_rst_data_bit2", tx_out, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_tx_out", tx_out, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ready", tx_ready, 1'b0);
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        check("mid_rst_release_ready", tx_ready, 1'b1);
        check("mid_rst_release_level", fifo_level, 0);
        send_check("after_rst", vecs[0]);

        // Random traffic with per-cycle random configuration
        for (int i = 0; i < 1500; i++) begin
            tx_valid    = ($urandom_range(0, 2) == 0);
            tx_data     = W'($urandom);
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
            tick();
        end
        tx_valid = 1'b0;
        wait_idle("rand");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
- Parametrised successor UART transmitter: LSB-first serialiser with configurable word width and a synchronous FIFO (power-of-2 depth) behind a valid/ready input handshake.
- Per-frame selectable parity (none/even/odd) and 1 or 2 stop bits.
- Sits between protocol/telemetry logic and the board TX pin; replaces the edge-triggered single-width transmitter.

Parameters:
CLKS_PER_BIT, 139, clocks per serial bit; must be >=2
WORDBITS, 8, data bits per frame; legal 5..9
FIFO_DEPTH, 16, input FIFO entries; power of 2, >=2

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
tx_data  in  WORDBITS  word to enqueue
tx_valid  in  1  tx_data valid
tx_ready  out  1  FIFO can accept; transfer when tx_valid&&tx_ready on rising edge
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  in  1  1 = two stop bits, 0 = one
tx_out  out  1  serial line, idle high, registered
busy  out  1  high when FIFO non-empty or a frame is in progress
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently in FIFO

Behaviour:
- Reset (async assert, sync release): tx_out=1, tx_ready=0 while reset_n low, then 1; busy=0; fifo_level=0; state IDLE; FIFO pointers 0. Mid-frame reset aborts the frame immediately; tx_out returns high in the same cycle; queued data discarded.
- tx_ready = (fifo_level != FIFO_DEPTH); registered/derived from level only, no combinational path from tx_valid or pop.
- Push and pop in the same cycle: level unchanged, both take effect. At full, no push occurs even if a pop happens that cycle.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; level carries the extra bit to distinguish full from empty.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1. If level!=0, pop the head into the shift register, latch parity_mode and two_stop, and go to START. Config changes mid-frame have no effect.
- START: tx_out=0 for CLKS_PER_BIT clocks, then DATA.
- DATA: drive shift[0] and shift right each bit period. After WORDBITS bits, go to PARITY if latched mode is even/odd, else STOP.
- PARITY: even drives XOR of data bits; odd drives its inverse. One bit period, then STOP.
- STOP: tx_out=1 for CLKS_PER_BIT clocks, or 2*CLKS_PER_BIT if two_stop was latched. Then go to IDLE, which pops on the next edge if the FIFO is non-empty.
- Bit timer counts 0..CLKS_PER_BIT-1 and resets on each bit boundary.
- Latency: a word accepted on edge E into an empty, idle block is popped on E+1; tx_out is first low after E+2.
- Frame length is exactly CLKS_PER_BIT*(1+WORDBITS+P+S) clocks, where P is 0/1 and S is 1/2.
- Inter-frame gap between back-to-back frames is exactly 1 clock (the IDLE pop cycle).
- Timer width is $clog2(CLKS_PER_BIT); bit counter width is $clog2(WORDBITS+1).

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD;
  - state encodings for IDLE..STOP;
  - shared clog2 helper constants.
- Sub-module uart_sync_fifo (params WIDTH, DEPTH; ports clock, reset_n, push, pop, din, dout, level, full, empty).
- Framing FSM stays in uart_tx_framed.

Test Plan:
- CLKS_PER_BIT=4, push 0xA5, parity none, one stop -> tx_out low after E+2. Bits (4 clocks each): 0,1,0,1,0,0,1,0,1,1. Frame is 40 clocks; busy falls the cycle after the stop bit.
- Push 0x07, even parity -> parity bit 1. Odd parity -> 0. Frames are 44 clocks.
- two_stop=1 with two words queued -> stop high for 8 clocks, 1-clock gap, second start bit. Toggling two_stop mid-frame does not change the current frame.
- From idle, hold tx_valid high 20 cycles -> exactly 17 words accepted; level=16; tx_ready low until first frame ends, then high 1 cycle after the next pop.
- Deassert reset_n during the 3rd data bit -> tx_out=1 and busy=0 the same cycle, fifo_level=0. After release, tx_ready=1 and a fresh push transmits correctly.
